// File: rtl/mac_decoder_pipe.sv
// Two-stage operand decoder for the MAC array: FP16 / FP8 E4M3 / INT9 lanes -> sign, exponent, mantissa, zero, special.
// Latency 2 cycles, 1 beat/cycle; o_ready depends only on i_ready and stage valids, so a stalled output holds the pipe.
package mac_decoder_pkg;
  typedef logic [1:0] mac_datatype;
  localparam mac_datatype DT_FP16 = 2'd0;
  localparam mac_datatype DT_FP8  = 2'd1;
  localparam mac_datatype DT_INT9 = 2'd2;
endpackage

module mac_decoder_pipe
  import mac_decoder_pkg::*;
#(
  parameter int LANES = 8,
  parameter bit NORM  = 1'b1
) (
  input  logic                 i_clk,
  input  logic                 i_rstn,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [1:0]           i_datatype,
  input  logic [LANES*16-1:0]  i_data,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [LANES-1:0]     o_iszero,
  output logic [LANES-1:0]     o_sign,
  output logic [LANES-1:0]     o_special,
  output logic [LANES*7-1:0]   o_exp,
  output logic [LANES*11-1:0]  o_mant
);

  logic s1_valid, s2_valid, s1_adv, s2_adv;

  assign s2_adv  = !s2_valid || i_ready;
  assign s1_adv  = !s1_valid || s2_adv;
  assign o_ready = s1_adv;
  assign o_valid = s2_valid;

  function automatic logic [3:0] msb_pos(input logic [9:0] f);
    msb_pos = 4'd0;
    for (int b = 0; b < 10; b++)
      if (f[b]) msb_pos = 4'(b);
  endfunction

  // Stage 1: field extraction and leading-one search
  logic [LANES-1:0]    x_sign, x_zero, x_special, x_sub;
  logic [LANES*5-1:0]  x_exp;
  logic [LANES*10-1:0] x_frac;
  logic [LANES*4-1:0]  x_msb;

  always_comb begin : p_extract
    logic [15:0] d;
    d         = '0;
    x_sign    = '0;
    x_zero    = '0;
    x_special = '0;
    x_sub     = '0;
    x_exp     = '0;
    x_frac    = '0;
    x_msb     = '0;
    for (int l = 0; l < LANES; l++) begin
      d = i_data[16*l +: 16];
      case (i_datatype)
        DT_FP16: begin
          x_sign[l]          = d[15];
          x_exp[5*l +: 5]    = d[14:10];
          x_frac[10*l +: 10] = d[9:0];
          x_zero[l]          = (d[14:0] == 15'd0);
          x_special[l]       = (d[14:10] == 5'h1F);
          x_sub[l]           = (d[14:10] == 5'd0) && (d[9:0] != 10'd0);
        end
        DT_FP8: begin
          x_sign[l]          = d[7];
          x_exp[5*l +: 5]    = {1'b0, d[6:3]};
          x_frac[10*l +: 10] = {7'd0, d[2:0]};
          x_zero[l]          = (d[6:0] == 7'd0);
          x_special[l]       = (d[6:0] == 7'h7F);
          x_sub[l]           = (d[6:3] == 4'd0) && (d[2:0] != 3'd0);
        end
        default: begin
          // INT9 (and the unused encoding): raw two's complement in the frac slot
          x_sign[l]          = d[8];
          x_frac[10*l +: 10] = {1'b0, d[8:0]};
          x_zero[l]          = (d[8:0] == 9'd0);
        end
      endcase
      x_msb[4*l +: 4] = msb_pos(x_frac[10*l +: 10]);
    end
  end

  mac_datatype         s1_dt;
  logic [LANES-1:0]    s1_sign, s1_zero, s1_special, s1_sub;
  logic [LANES*5-1:0]  s1_exp;
  logic [LANES*10-1:0] s1_frac;
  logic [LANES*4-1:0]  s1_msb;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      s1_valid   <= 1'b0;
      s1_dt      <= DT_FP16;
      s1_sign    <= '0;
      s1_zero    <= '0;
      s1_special <= '0;
      s1_sub     <= '0;
      s1_exp     <= '0;
      s1_frac    <= '0;
      s1_msb     <= '0;
    end else if (s1_adv) begin
      s1_valid <= i_valid;
      if (i_valid) begin
        s1_dt      <= i_datatype;
        s1_sign    <= x_sign;
        s1_zero    <= x_zero;
        s1_special <= x_special;
        s1_sub     <= x_sub;
        s1_exp     <= x_exp;
        s1_frac    <= x_frac;
        s1_msb     <= x_msb;
      end
    end
  end

  // Stage 2: subnormal alignment and final exponent
  logic [LANES*7-1:0]  n_exp;
  logic [LANES*11-1:0] n_mant;

  always_comb begin : p_align
    logic [3:0]  h_pos;
    logic [3:0]  sh;
    logic [10:0] base;
    n_exp  = '0;
    n_mant = '0;
    sh     = '0;
    base   = '0;
    h_pos  = (s1_dt == DT_FP16) ? 4'd10 : 4'd3;
    for (int l = 0; l < LANES; l++) begin
      base = {1'b0, s1_frac[10*l +: 10]};
      sh   = h_pos - s1_msb[4*l +: 4];
      if (s1_dt != DT_FP16 && s1_dt != DT_FP8) begin
        n_mant[11*l +: 11] = base;
      end else if (s1_zero[l]) begin
        n_mant[11*l +: 11] = 11'd0;
      end else if (s1_sub[l]) begin
        if (NORM) begin
          n_mant[11*l +: 11] = base << sh;
          n_exp[7*l +: 7]    = 7'd1 - {3'd0, sh};
        end else begin
          n_mant[11*l +: 11] = base;
          n_exp[7*l +: 7]    = 7'd1;
        end
      end else begin
        n_mant[11*l +: 11] = base | (11'd1 << h_pos);
        n_exp[7*l +: 7]    = {2'd0, s1_exp[5*l +: 5]};
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      s2_valid  <= 1'b0;
      o_iszero  <= '0;
      o_sign    <= '0;
      o_special <= '0;
      o_exp     <= '0;
      o_mant    <= '0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        o_iszero  <= s1_zero;
        o_sign    <= s1_sign;
        o_special <= s1_special;
        o_exp     <= n_exp;
        o_mant    <= n_mant;
      end
    end
  end

endmodule

// File: tb/tb_mac_decoder_pipe.sv
// Directed vector table plus stream, random-backpressure and mid-stall reset sequences for mac_decoder_pipe.
module tb_mac_decoder_pipe;
  localparam int L = 8;
  typedef logic [167:0] beat_t;

  logic         i_clk = 1'b0;
  logic         i_rstn, i_valid, i_ready;
  logic [1:0]   i_datatype;
  logic [L*16-1:0] i_data;
  logic         o_ready1, o_valid1, o_ready0, o_valid0;
  logic [L-1:0] z1, s1, sp1, z0, s0, sp0;
  logic [L*7-1:0]  e1, e0;
  logic [L*11-1:0] m1, m0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 i_clk = ~i_clk;

  mac_decoder_pipe #(.LANES(L), .NORM(1'b1)) dut (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_valid(i_valid), .o_ready(o_ready1),
    .i_datatype(i_datatype), .i_data(i_data), .o_valid(o_valid1), .i_ready(i_ready),
    .o_iszero(z1), .o_sign(s1), .o_special(sp1), .o_exp(e1), .o_mant(m1));

  mac_decoder_pipe #(.LANES(L), .NORM(1'b0)) dut0 (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_valid(i_valid), .o_ready(o_ready0),
    .i_datatype(i_datatype), .i_data(i_data), .o_valid(o_valid0), .i_ready(i_ready),
    .o_iszero(z0), .o_sign(s0), .o_special(sp0), .o_exp(e0), .o_mant(m0));

  wire beat_t act1 = {z1, s1, sp1, e1, m1};
  wire beat_t act0 = {z0, s0, sp0, e0, m0};

  task automatic chk(input string name, input beat_t act, input beat_t exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference decode of one lane: {zero, sign, special, exp[6:0], mant[10:0]}
  function automatic logic [20:0] ref_lane(input logic [1:0] dt, input logic [15:0] d, input bit norm);
    logic z, s, sp;
    logic [6:0] e;
    logic [10:0] m;
    int ex, fr, h, x, mm;
    z = 1'b0; s = 1'b0; sp = 1'b0; e = '0; m = '0;
    if (dt == 2'd0 || dt == 2'd1) begin
      if (dt == 2'd0) begin
        s = d[15]; ex = int'(d[14:10]); fr = int'(d[9:0]); h = 10;
        z = (d[14:0] == 0); sp = (ex == 31);
      end else begin
        s = d[7]; ex = int'(d[6:3]); fr = int'(d[2:0]); h = 3;
        z = (d[6:0] == 0); sp = (d[6:0] == 7'h7F);
      end
      if (z) begin
        e = '0; m = '0;
      end else if (ex == 0) begin
        if (norm) begin
          mm = fr; x = 1;
          while (mm < (1 << h)) begin
            mm = mm * 2;
            x = x - 1;
          end
          e = 7'(x); m = 11'(mm);
        end else begin
          e = 7'd1; m = 11'(fr);
        end
      end else begin
        e = 7'(ex); m = 11'((1 << h) + fr);
      end
    end else begin
      s = d[8]; z = (d[8:0] == 0); m = {2'b00, d[8:0]};
    end
    return {z, s, sp, e, m};
  endfunction

  function automatic beat_t ref_beat(input logic [1:0] dt, input logic [L*16-1:0] bus, input bit norm);
    logic [L-1:0] z, s, sp;
    logic [L*7-1:0] e;
    logic [L*11-1:0] m;
    logic [20:0] r;
    for (int l = 0; l < L; l++) begin
      r = ref_lane(dt, bus[16*l +: 16], norm);
      z[l] = r[20]; s[l] = r[19]; sp[l] = r[18];
      e[7*l +: 7] = r[17:11];
      m[11*l +: 11] = r[10:0];
    end
    return {z, s, sp, e, m};
  endfunction

  typedef struct {
    logic [1:0]  dt;
    logic [15:0] d;
    logic        z, s, sp;
    logic [6:0]  e1;
    logic [10:0] m1;
    logic [6:0]  e0;
    logic [10:0] m0;
  } vec_t;

  vec_t  tv[16];
  beat_t q1[$], q0[$];
  beat_t held_val, exp_b;
  logic  held, saw_valid;
  logic [L*16-1:0] bus;

  initial begin
    tv[0]  = '{2'd0, 16'h3C00, 1'b0, 1'b0, 1'b0, 7'h0F, 11'h400, 7'h0F, 11'h400};
    tv[1]  = '{2'd0, 16'h0001, 1'b0, 1'b0, 1'b0, 7'h77, 11'h400, 7'h01, 11'h001};
    tv[2]  = '{2'd1, 16'h0001, 1'b0, 1'b0, 1'b0, 7'h7E, 11'h008, 7'h01, 11'h001};
    tv[3]  = '{2'd0, 16'h7C00, 1'b0, 1'b0, 1'b1, 7'h1F, 11'h400, 7'h1F, 11'h400};
    tv[4]  = '{2'd1, 16'h007F, 1'b0, 1'b0, 1'b1, 7'h0F, 11'h00F, 7'h0F, 11'h00F};
    tv[5]  = '{2'd1, 16'h0038, 1'b0, 1'b0, 1'b0, 7'h07, 11'h008, 7'h07, 11'h008};
    tv[6]  = '{2'd1, 16'h0080, 1'b1, 1'b1, 1'b0, 7'h00, 11'h000, 7'h00, 11'h000};
    tv[7]  = '{2'd0, 16'h8000, 1'b1, 1'b1, 1'b0, 7'h00, 11'h000, 7'h00, 11'h000};
    tv[8]  = '{2'd2, 16'h01FF, 1'b0, 1'b1, 1'b0, 7'h00, 11'h1FF, 7'h00, 11'h1FF};
    tv[9]  = '{2'd2, 16'hFE00, 1'b1, 1'b0, 1'b0, 7'h00, 11'h000, 7'h00, 11'h000};
    tv[10] = '{2'd0, 16'h0200, 1'b0, 1'b0, 1'b0, 7'h00, 11'h400, 7'h01, 11'h200};
    tv[11] = '{2'd1, 16'h0004, 1'b0, 1'b0, 1'b0, 7'h00, 11'h008, 7'h01, 11'h004};
    tv[12] = '{2'd0, 16'hFBFF, 1'b0, 1'b1, 1'b0, 7'h1E, 11'h7FF, 7'h1E, 11'h7FF};
    tv[13] = '{2'd1, 16'hABF7, 1'b0, 1'b1, 1'b0, 7'h0E, 11'h00F, 7'h0E, 11'h00F};
    tv[14] = '{2'd0, 16'h03FF, 1'b0, 1'b0, 1'b0, 7'h00, 11'h7FE, 7'h01, 11'h3FF};
    tv[15] = '{2'd1, 16'h007E, 1'b0, 1'b0, 1'b0, 7'h0F, 11'h00E, 7'h0F, 11'h00E};

    i_rstn = 1'b0; i_valid = 1'b0; i_ready = 1'b1; i_datatype = 2'd0; i_data = '0;
    #3;
    chk("reset_valid", beat_t'(o_valid1), beat_t'(0));
    chk("reset_outputs", act1, '0);
    #9 i_rstn = 1'b1;
    @(negedge i_clk);
    chk("ready_after_reset", beat_t'(o_ready1), beat_t'(1));

    // Directed vectors, all lanes carry the same operand
    foreach (tv[i]) begin
      @(posedge i_clk); #1;
      i_valid = 1'b1; i_datatype = tv[i].dt; i_data = {L{tv[i].d}};
      @(posedge i_clk); #1;
      i_valid = 1'b0;
      @(negedge i_clk);
      chk($sformatf("vec%0d_valid", i), beat_t'(o_valid1), beat_t'(0));
      @(posedge i_clk);
      @(negedge i_clk);
      chk($sformatf("vec%0d_valid", i), beat_t'(o_valid1), beat_t'(1));
      chk($sformatf("vec%0d_norm1", i), act1,
          {{L{tv[i].z}}, {L{tv[i].s}}, {L{tv[i].sp}}, {L{tv[i].e1}}, {L{tv[i].m1}}});
      chk($sformatf("vec%0d_norm0", i), act0,
          {{L{tv[i].z}}, {L{tv[i].s}}, {L{tv[i].sp}}, {L{tv[i].e0}}, {L{tv[i].m0}}});
    end

    // Eight back-to-back FP16 beats with distinct values per lane
    for (int c = 0; c <= 10; c++) begin
      @(posedge i_clk); #1;
      if (c < 8) begin
        i_valid = 1'b1; i_datatype = 2'd0;
        for (int l = 0; l < L; l++) i_data[16*l +: 16] = 16'h3C00 + 16'(c * 8 + l);
      end else begin
        i_valid = 1'b0;
      end
      @(negedge i_clk);
      chk($sformatf("stream%0d_valid", c), beat_t'(o_valid1), beat_t'(c >= 2 && c < 10));
      if (c >= 2 && c < 10) begin
        for (int l = 0; l < L; l++) bus[16*l +: 16] = 16'h3C00 + 16'((c - 2) * 8 + l);
        chk($sformatf("stream%0d_data", c), act1, ref_beat(2'd0, bus, 1'b1));
      end
    end

    // Random backpressure with mixed datatypes
    held = 1'b0;
    held_val = '0;
    for (int c = 0; c < 400; c++) begin
      @(posedge i_clk); #1;
      i_ready = ($urandom_range(0, 9) < 3);
      i_valid = ($urandom_range(0, 3) != 0);
      i_datatype = 2'($urandom_range(0, 2));
      for (int l = 0; l < L; l++) begin
        i_data[16*l +: 16] = 16'($urandom);
        if ($urandom_range(0, 3) == 0) i_data[16*l +: 16] &= 16'h83FF;
      end
      @(negedge i_clk);
      chk("bp_ready", beat_t'(o_ready1), beat_t'(!(q1.size() == 2 && !i_ready)));
      if (held) begin
        chk("bp_hold_valid", beat_t'(o_valid1), beat_t'(1));
        chk("bp_hold_data", act1, held_val);
      end
      if (o_valid1 && i_ready) begin
        if (q1.size() == 0) begin
          chk("bp_unexpected_beat", beat_t'(o_valid1), beat_t'(0));
        end else begin
          exp_b = q1.pop_front();
          chk("bp_pop_norm1", act1, exp_b);
          exp_b = q0.pop_front();
          chk("bp_pop_norm0", act0, exp_b);
        end
      end
      held = o_valid1 && !i_ready;
      held_val = act1;
      if (i_valid && o_ready1) begin
        q1.push_back(ref_beat(i_datatype, i_data, 1'b1));
        q0.push_back(ref_beat(i_datatype, i_data, 1'b0));
      end
    end
    @(posedge i_clk); #1;
    i_valid = 1'b0; i_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge i_clk);
      if (o_valid1 && q1.size() != 0) begin
        exp_b = q1.pop_front();
        chk("drain_pop", act1, exp_b);
        void'(q0.pop_front());
      end
      @(posedge i_clk); #1;
    end
    chk("drain_empty", beat_t'(q1.size()), beat_t'(0));

    // Mid-stall reset
    @(posedge i_clk); #1;
    i_ready = 1'b0; i_valid = 1'b1; i_datatype = 2'd0; i_data = {L{16'h3C00}};
    @(posedge i_clk); #1;
    i_data = {L{16'h4000}};
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    @(negedge i_clk);
    chk("stall_full_ready", beat_t'(o_ready1), beat_t'(0));
    chk("stall_full_valid", beat_t'(o_valid1), beat_t'(1));
    #2 i_rstn = 1'b0;
    #1;
    chk("midrst_valid", beat_t'(o_valid1), beat_t'(0));
    chk("midrst_outputs", act1, '0);
    chk("midrst_ready", beat_t'(o_ready1), beat_t'(1));
    @(posedge i_clk); #3;
    i_rstn = 1'b1; i_ready = 1'b1;
    saw_valid = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge i_clk);
      if (o_valid1) saw_valid = 1'b1;
    end
    chk("midrst_no_stale", beat_t'(saw_valid), beat_t'(0));

    @(posedge i_clk); #1;
    i_valid = 1'b1; i_datatype = 2'd1; i_data = {L{16'h0038}};
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    @(posedge i_clk);
    @(negedge i_clk);
    chk("post_rst_beat", act1, {{L{1'b0}}, {L{1'b0}}, {L{1'b0}}, {L{7'h07}}, {L{11'h008}}});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
